// File: rtl/uart_fifo_ctr.sv
// Memory-mapped UART controller: TX/RX FIFOs, occupancy and sticky status registers,
// flush/clear command, registered load data returned one cycle after the load.
module uart_fifo_ctr #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic                  load_en,
  input  logic                  store_en,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [DATA_WIDTH-1:0] uart_tx_data,
  output logic                  uart_tx_valid,
  input  logic                  uart_tx_ready,
  input  logic [DATA_WIDTH-1:0] uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic                  uart_rx_ready
);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXCW = TXAW + 1;
  localparam int RXCW = RXAW + 1;

  logic [DATA_WIDTH-1:0] txMem [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rxMem [RX_DEPTH];
  logic [TXAW-1:0]       txWr, txRd;
  logic [RXAW-1:0]       rxWr, rxRd;
  logic [TXCW-1:0]       txCount;
  logic [RXCW-1:0]       rxCount;
  logic                  txDrop, rxOverflow;

  logic       ldSel, stSel;
  logic [2:0] offset;
  logic       flush, clrFlags;
  logic       txFull, txPush, txAccept, txDropSet, txDrain;
  logic       rxEmpty, rxFull, rxPop, rxPush, rxAccept, rxOvfSet;
  logic [31:0] readMux;
  logic       unusedBits;

  assign offset   = addr[4:2];
  assign ldSel    = (addr[31:28] == 4'b1000) && load_en;
  assign stSel    = (addr[31:28] == 4'b1000) && store_en;
  assign flush    = stSel && (offset == 3'd5) && wdata[1];
  assign clrFlags = stSel && (offset == 3'd5) && wdata[0];

  // Full test uses the cycle-start count, so a same-cycle drain never rescues a push.
  assign txFull    = (txCount == TXCW'(TX_DEPTH));
  assign txPush    = stSel && (offset == 3'd2);
  assign txAccept  = txPush && !txFull && !flush;
  assign txDropSet = txPush && txFull && !flush;
  assign txDrain   = uart_tx_valid && uart_tx_ready && !flush;

  // A pop while full frees the slot the incoming byte takes.
  assign rxEmpty  = (rxCount == '0);
  assign rxFull   = (rxCount == RXCW'(RX_DEPTH));
  assign rxPop    = ldSel && (offset == 3'd3) && !rxEmpty && !flush;
  assign rxPush   = uart_rx_valid && uart_rx_ready && !flush;
  assign rxAccept = rxPush && (!rxFull || rxPop);
  assign rxOvfSet = rxPush && rxFull && !rxPop;

  assign uart_tx_valid = (txCount != '0);
  assign uart_tx_data  = uart_tx_valid ? txMem[txRd] : '0;

  assign unusedBits = &{1'b0, addr[27:5], addr[1:0], wdata};

  always_comb begin
    readMux = '0;
    case (offset)
      3'd0: readMux[0] = !txFull;
      3'd1: readMux[0] = !rxEmpty;
      3'd3: if (!rxEmpty) readMux[DATA_WIDTH-1:0] = rxMem[rxRd];
      3'd4: begin
        readMux[31:16] = 16'(rxCount);
        readMux[15:0]  = 16'(txCount);
      end
      3'd5: readMux[2:0] = {txCount == '0, txDrop, rxOverflow};
      default: readMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (txAccept) txMem[txWr] <= wdata[DATA_WIDTH-1:0];
    if (rxAccept) rxMem[rxWr] <= uart_rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txWr          <= '0;
      txRd          <= '0;
      txCount       <= '0;
      rxWr          <= '0;
      rxRd          <= '0;
      rxCount       <= '0;
      txDrop        <= 1'b0;
      rxOverflow    <= 1'b0;
      rdata         <= '0;
      uart_rx_ready <= 1'b0;
    end else begin
      uart_rx_ready <= 1'b1;
      if (ldSel) rdata <= readMux;
      // Set has priority over a same-cycle clear.
      txDrop     <= txDropSet | (txDrop & ~clrFlags);
      rxOverflow <= rxOvfSet | (rxOverflow & ~clrFlags);
      if (flush) begin
        txWr    <= '0;
        txRd    <= '0;
        txCount <= '0;
        rxWr    <= '0;
        rxRd    <= '0;
        rxCount <= '0;
      end else begin
        if (txAccept) txWr <= txWr + 1'b1;
        if (txDrain)  txRd <= txRd + 1'b1;
        txCount <= txCount + TXCW'(txAccept) - TXCW'(txDrain);
        if (rxAccept) rxWr <= rxWr + 1'b1;
        if (rxPop)    rxRd <= rxRd + 1'b1;
        rxCount <= rxCount + RXCW'(rxAccept) - RXCW'(rxPop);
      end
    end
  end
endmodule

// File: doc/uart_fifo_ctr.md
# uart_fifo_ctr

Memory-mapped UART controller for the MIPS pipeline, successor to the single-byte UART control path. Parametrised TX and RX FIFOs decouple the memory stage from the serial transmitter and receiver. Adds an occupancy register, sticky drop/overflow flags and a flush command. It sits on the memory-stage address/data bus beside data and instruction memory, and returns load data to writeback one cycle later.

## Interface
- DATA_WIDTH, 8: UART character width; must be ≤ 16.
- TX_DEPTH, 8: TX FIFO entries; power of two, ≥ 2.
- RX_DEPTH, 8: RX FIFO entries; power of two, ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- addr  in  32  memory-stage address (ALUOutM).
- load_en  in  1  memory-stage load instruction valid.
- store_en  in  1  memory-stage store instruction valid.
- wdata  in  32  store data.
- rdata  out  32  load data, registered, zero-extended.
- uart_tx_data  out  DATA_WIDTH  head of TX FIFO.
- uart_tx_valid  out  1  TX FIFO not empty.
- uart_tx_ready  in  1  transmitter accepts a character.
- uart_rx_data  in  DATA_WIDTH  received character.
- uart_rx_valid  in  1  receiver presents a character.
- uart_rx_ready  out  1  0 in reset, 1 otherwise; receiver never back-pressured.

## Operation
- Selected access: addr[31:28]==4'b1000 with load_en or store_en. Offset is addr[4:2]. Other addresses are ignored.
- Register map:
  - 0x00 R: bit0 = TX not full.
  - 0x04 R: bit0 = RX not empty.
  - 0x08 W: push wdata[DATA_WIDTH-1:0] into TX.
  - 0x0C R: pop RX head.
  - 0x10 R: [31:16] RX count, [15:0] TX count.
  - 0x14 R: bit0 rx_overflow, bit1 tx_drop, bit2 TX empty. 0x14 W: bit0=1 clears both sticky flags; bit1=1 flushes both FIFOs.
- Unmapped or write-only offsets read 0. Stores to read-only offsets are ignored.
- TX push: a push when the cycle-start TX count == TX_DEPTH is discarded and sets tx_drop. A same-cycle drain does not rescue it.
- TX drain: occurs when uart_tx_valid && uart_tx_ready. Push and drain in the same non-full cycle both occur, and the count is unchanged.
- RX push: happens on uart_rx_valid. If RX is full and no pop occurs the same cycle, the byte is discarded and rx_overflow is set. If a pop occurs while full, the push is accepted and the count is unchanged.
- RX pop when empty: returns 0, no state change.
- Counts are full-width: 0..DEPTH inclusive. Read/write pointers wrap modulo DEPTH.
- Flush: clears pointers and counts and ignores every other push and pop in that cycle. Sticky flags are kept unless bit0 is also set.
- Flag set and clear in the same cycle: the set wins.
- No internal FSM beyond the FIFO pointers. There is no stall output; software polls the status offsets.

## Timing
- Reset values: rdata=0, uart_tx_valid=0, uart_tx_data=0, uart_rx_ready=0, counts 0, flags 0. Reset is honoured immediately mid-operation and aborts pending pushes and pops.
- Load latency: 1 cycle. rdata is captured at the edge where the load is presented and holds until the next selected load. Status reads reflect pre-edge state.
- RX pop takes effect at the same edge that captures rdata.
- TX latency: a store to an empty FIFO raises uart_tx_valid the cycle after the store edge. uart_tx_data is the registered head, stable while valid && !ready.
- RX latency: a byte accepted at edge N is visible in 0x04/0x10 reads presented after edge N.
- load_en and store_en both asserted: the store acts and rdata updates; the simultaneous 0x0C pop still occurs.

## Test plan
- Reset: assert rst mid-stream with 3 TX bytes queued -> all outputs 0, uart_tx_valid=0, 0x10 reads 0 after release; uart_rx_ready=1 the cycle after release.
- TX fill: uart_tx_ready=0, store 0x41..0x49 to 0x80000008 -> 8 accepted, 9th drops. Status: 0x00=0, 0x14 bit1=1, 0x10=0x00000008. Then raise ready -> 0x41..0x48 emitted in order, one per cycle.
- RX order/latency: drive 0x55,0xAA on rx -> 0x04 reads 1; loads from 0x0C return 0x55 then 0xAA on rdata one cycle after each load; a third load returns 0.
- RX overflow: push 9 bytes with no pops -> 0x14 bit0=1, count stays 8. A 9th push coincident with a pop is accepted and the count stays 8.
- Simultaneous TX push/drain at count 4 -> count stays 4. Push at count 8 with same-cycle drain -> dropped, count 7.
- Flush + clear: store 0x3 to 0x80000014 while both FIFOs are partly full and rx_valid is high -> counts 0, flags 0, incoming byte ignored, uart_tx_valid=0 next cycle.
